// File: rtl/wmem_layer_scheduler.sv
// Loop sequencer for the bit-serial multi-layer engine: walks layer/group/input/bit
// loops, owns the weight-memory port and drives the P-lane accumulator strobes.
module wmem_layer_scheduler #(
  parameter int PRECISION = 16,
  parameter int N_IN      = 512,
  parameter int N_HIDDEN  = 256,
  parameter int N_LAYERS  = 7,
  parameter int P         = 4,
  parameter int DATA_W    = 16,
  localparam int LW = (N_LAYERS > 1)      ? $clog2(N_LAYERS)     : 1,
  localparam int HW = (N_HIDDEN > 1)      ? $clog2(N_HIDDEN)     : 1,
  localparam int IW = (N_IN > 1)          ? $clog2(N_IN)         : 1,
  localparam int BW = (PRECISION > 1)     ? $clog2(PRECISION)    : 1,
  localparam int GW = ((N_HIDDEN/P) > 1)  ? $clog2(N_HIDDEN/P)   : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  input  logic              w_req,
  output logic              w_ready,
  input  logic [LW-1:0]     w_addr_l,
  input  logic [HW-1:0]     w_addr_h,
  input  logic [IW-1:0]     w_addr_i,
  input  logic [DATA_W-1:0] w_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [LW-1:0]     mem_l,
  output logic [HW-1:0]     mem_h,
  output logic [IW-1:0]     mem_i,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BW-1:0]     bit_idx,
  output logic              bit_msb,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              acc_wb,
  output logic [LW-1:0]     wb_layer,
  output logic [GW-1:0]     wb_group
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IW-1:0] FAN0_LAST = IW'(N_IN - 1);
  localparam logic [IW-1:0] FANH_LAST = IW'(N_HIDDEN - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PRECISION - 1);
  localparam logic [GW-1:0] GRP_LAST  = GW'(N_HIDDEN / P - 1);
  localparam logic [LW-1:0] LYR_LAST  = LW'(N_LAYERS - 1);

  state_t        r_state, w_state_next;
  logic [LW-1:0] r_l, w_l_next;
  logic [GW-1:0] r_g, w_g_next;
  logic [IW-1:0] r_i, w_i_next;
  logic [BW-1:0] r_b, w_b_next;
  logic [IW-1:0] w_in_last;
  logic [HW-1:0] w_grp_base;

  // Layer 0 reads the external inputs; deeper layers read the previous hidden layer.
  assign w_in_last  = (r_l == '0) ? FAN0_LAST : FANH_LAST;
  assign w_grp_base = HW'(r_g * P);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_l     <= '0;
      r_g     <= '0;
      r_i     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_next;
      r_l     <= w_l_next;
      r_g     <= w_g_next;
      r_i     <= w_i_next;
      r_b     <= w_b_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_l_next     = r_l;
    w_g_next     = r_g;
    w_i_next     = r_i;
    w_b_next     = r_b;
    busy         = 1'b0;
    done         = 1'b0;
    w_ready      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_l        = '0;
    mem_h        = '0;
    mem_i        = '0;
    mem_wdata    = '0;
    bit_idx      = '0;
    bit_msb      = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    acc_wb       = 1'b0;
    wb_layer     = '0;
    wb_group     = '0;

    unique case (r_state)
      S_IDLE: begin
        // Host writes own the port only while idle; a coincident start still goes ahead.
        if (w_req) begin
          w_ready   = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_l     = w_addr_l;
          mem_h     = w_addr_h;
          mem_i     = w_addr_i;
          mem_wdata = w_data;
        end
        if (start) begin
          w_state_next = S_CLEAR;
          w_l_next     = '0;
          w_g_next     = '0;
          w_i_next     = '0;
          w_b_next     = '0;
        end
      end
      S_CLEAR: begin
        busy         = 1'b1;
        acc_clr      = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        mem_en  = !stall;
        acc_en  = !stall;
        mem_l   = r_l;
        mem_h   = w_grp_base;
        mem_i   = r_i;
        bit_idx = r_b;
        bit_msb = (r_b == BIT_LAST);
        if (!stall) begin
          if (r_b == BIT_LAST) begin
            w_b_next = '0;
            if (r_i == w_in_last) begin
              w_i_next     = '0;
              w_state_next = S_WB;
            end else begin
              w_i_next = r_i + IW'(1);
            end
          end else begin
            w_b_next = r_b + BW'(1);
          end
        end
      end
      S_WB: begin
        busy         = 1'b1;
        acc_wb       = 1'b1;
        wb_layer     = r_l;
        wb_group     = r_g;
        w_state_next = S_CLEAR;
        if (r_g == GRP_LAST) begin
          w_g_next = '0;
          if (r_l == LYR_LAST) begin
            w_l_next     = '0;
            w_state_next = S_DONE;
          end else begin
            w_l_next = r_l + LW'(1);
          end
        end else begin
          w_g_next = r_g + GW'(1);
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (abort) begin
      w_state_next = S_IDLE;
      w_l_next     = '0;
      w_g_next     = '0;
      w_i_next     = '0;
      w_b_next     = '0;
    end
  end

endmodule

// File: tb/tb_wmem_layer_scheduler.sv
// Directed bench for wmem_layer_scheduler on a small 2-layer, 8x8, P=4, 4-bit configuration.
module tb_wmem_layer_scheduler;

  localparam int PRECISION = 4;
  localparam int N_IN      = 8;
  localparam int N_HIDDEN  = 8;
  localparam int N_LAYERS  = 2;
  localparam int P         = 4;
  localparam int DATA_W    = 16;
  localparam int LW = 1, HW = 3, IW = 3, BW = 2, GW = 1;
  localparam int MAXC = 170;

  logic              clk = 1'b0;
  logic              rst, start, abort, stall, w_req;
  logic              busy, done, w_ready, mem_en, mem_we, bit_msb, acc_clr, acc_en, acc_wb;
  logic [LW-1:0]     w_addr_l, mem_l, wb_layer;
  logic [HW-1:0]     w_addr_h, mem_h;
  logic [IW-1:0]     w_addr_i, mem_i;
  logic [DATA_W-1:0] w_data, mem_wdata;
  logic [BW-1:0]     bit_idx;
  logic [GW-1:0]     wb_group;

  wmem_layer_scheduler #(
    .PRECISION(PRECISION), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN),
    .N_LAYERS(N_LAYERS), .P(P), .DATA_W(DATA_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .busy(busy), .done(done), .w_req(w_req), .w_ready(w_ready),
    .w_addr_l(w_addr_l), .w_addr_h(w_addr_h), .w_addr_i(w_addr_i), .w_data(w_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_l(mem_l), .mem_h(mem_h), .mem_i(mem_i),
    .mem_wdata(mem_wdata), .bit_idx(bit_idx), .bit_msb(bit_msb),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_wb(acc_wb),
    .wb_layer(wb_layer), .wb_group(wb_group)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          clr, en, wb, dn, bsy, msb, men, mwe, wrdy;
    logic [LW-1:0] ml;
    logic [HW-1:0] mh;
    logic [IW-1:0] mi;
    logic [BW-1:0] bi;
    logic [LW-1:0] wl;
    logic [GW-1:0] wg;
  } snap_t;

  snap_t rec [0:MAXC-1];
  int n_vec  = 0;
  int n_miss = 0;

  // stats gathered over one recorded pass
  int n_en, n_msb, n_done, n_clr, first_done, first_idle, n_bus_wr, n_wb_after, n_en_after;
  int wb_cyc [$];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // start pulse sampled at edge T0; cycle c is the cycle following edge T0+c-1
  task automatic run_pass(input int stall_from, input int stall_len, input int abort_at,
                          input int rst_at, input bit wreq_hold);
    @(negedge clk);
    start = 1'b1;
    if (wreq_hold) begin
      w_req = 1'b1; w_addr_l = 1'b0; w_addr_h = 3'd2; w_addr_i = 3'd6; w_data = 16'hBEEF;
      #1;
      chk("coincident w_ready", int'(w_ready), 1);
      chk("coincident mem_we", int'(mem_we), 1);
      chk("coincident wdata", int'(mem_wdata), 16'hBEEF);
    end
    @(posedge clk);
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      start = 1'b0;
      stall = (c >= stall_from) && (c < stall_from + stall_len);
      abort = (c == abort_at);
      rst   = (c == rst_at);
      #1;
      rec[c] = '{clr: acc_clr, en: acc_en, wb: acc_wb, dn: done, bsy: busy, msb: bit_msb,
                 men: mem_en, mwe: mem_we, wrdy: w_ready, ml: mem_l, mh: mem_h, mi: mem_i,
                 bi: bit_idx, wl: wb_layer, wg: wb_group};
    end
    @(negedge clk);
    stall = 1'b0; abort = 1'b0; rst = 1'b0; w_req = 1'b0;
  endtask

  task automatic stats(input int from);
    n_en = 0; n_msb = 0; n_done = 0; n_clr = 0; first_done = -1; first_idle = -1;
    n_bus_wr = 0; n_wb_after = 0; n_en_after = 0;
    wb_cyc.delete();
    for (int c = 1; c < MAXC; c++) begin
      if (rec[c].en) n_en++;
      if (rec[c].en && rec[c].msb) n_msb++;
      if (rec[c].clr) n_clr++;
      if (rec[c].dn) begin n_done++; if (first_done < 0) first_done = c; end
      if (!rec[c].bsy && first_idle < 0) first_idle = c;
      if (rec[c].bsy && (rec[c].wrdy || rec[c].mwe)) n_bus_wr++;
      if (rec[c].wb) wb_cyc.push_back(c);
      if (c > from && rec[c].wb) n_wb_after++;
      if (c >= from && rec[c].en) n_en_after++;
    end
  endtask

  task automatic check_nominal(input string pfx);
    stats(MAXC);
    chk({pfx, " acc_clr cycle1"}, int'(rec[1].clr), 1);
    chk({pfx, " acc_en cycle2"}, int'(rec[2].en), 1);
    chk({pfx, " acc_en cycle33"}, int'(rec[33].en), 1);
    chk({pfx, " acc_en cycle34"}, int'(rec[34].en), 0);
    chk({pfx, " acc_en total"}, n_en, 128);
    chk({pfx, " wb count"}, wb_cyc.size(), 4);
    if (wb_cyc.size() == 4) begin
      chk({pfx, " wb0 cycle"}, wb_cyc[0], 34);
      chk({pfx, " wb1 cycle"}, wb_cyc[1], 68);
      chk({pfx, " wb2 cycle"}, wb_cyc[2], 102);
      chk({pfx, " wb3 cycle"}, wb_cyc[3], 136);
    end
    chk({pfx, " done cycle"}, first_done, 137);
    chk({pfx, " done count"}, n_done, 1);
    chk({pfx, " busy low cycle"}, first_idle, 138);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; w_req = 1'b0;
    w_addr_l = '0; w_addr_h = '0; w_addr_i = '0; w_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset mem_en", int'(mem_en), 0);
    chk("reset acc_en/clr/wb/done", int'({acc_en, acc_clr, acc_wb, done}), 0);

    // host write in IDLE: combinational passthrough
    w_req = 1'b1; w_addr_l = 1'b1; w_addr_h = 3'd5; w_addr_i = 3'd3; w_data = 16'h1234;
    #1;
    chk("idle w_ready", int'(w_ready), 1);
    chk("idle mem_en/we", int'({mem_en, mem_we}), 3);
    chk("idle mem_l", int'(mem_l), 1);
    chk("idle mem_h", int'(mem_h), 5);
    chk("idle mem_i", int'(mem_i), 3);
    chk("idle mem_wdata", int'(mem_wdata), 16'h1234);
    @(negedge clk);
    w_req = 1'b0;

    // nominal pass with address sweep and bit_msb cadence
    run_pass(0, 0, -1, -1, 1'b0);
    check_nominal("pass");
    chk("msb count", n_msb, 32);
    chk("read1 addr l/h/i/b", int'({rec[2].ml, rec[2].mh, rec[2].mi, rec[2].bi}), 0);
    chk("read3 msb", int'(rec[4].msb), 0);
    chk("read4 bit", int'(rec[5].bi), 3);
    chk("read4 msb", int'(rec[5].msb), 1);
    chk("read4 mem_i", int'(rec[5].mi), 0);
    chk("read5 mem_i", int'(rec[6].mi), 1);
    chk("read5 bit", int'(rec[6].bi), 0);
    chk("g1 mem_h", int'(rec[36].mh), 4);
    chk("L1g1 mem_l", int'(rec[104].ml), 1);
    chk("L1g1 mem_h", int'(rec[104].mh), 4);
    chk("wb1 layer/group", int'({rec[68].wl, rec[68].wg}), 1);
    chk("wb2 layer/group", int'({rec[102].wl, rec[102].wg}), 2);
    chk("wb3 layer/group", int'({rec[136].wl, rec[136].wg}), 3);

    // five stalled cycles in group 0 (cycles 20..24): read 19 = i4,b2 held
    run_pass(20, 5, -1, -1, 1'b0);
    stats(MAXC);
    chk("stall acc_en c22", int'(rec[22].en), 0);
    chk("stall mem_en c22", int'(rec[22].men), 0);
    chk("stall held mem_i", int'(rec[22].mi), 4);
    chk("stall held bit", int'(rec[22].bi), 2);
    chk("stall resume en c25", int'(rec[25].en), 1);
    chk("stall resume i/b", int'({rec[25].mi, rec[25].bi}), {3'd4, 2'd2});
    chk("stall resume next b", int'(rec[26].bi), 3);
    chk("stall acc_en total", n_en, 128);
    chk("stall done cycle", first_done, 142);

    // coincident start + write, with w_req held through busy
    run_pass(0, 0, -1, -1, 1'b1);
    stats(MAXC);
    chk("busy write leak", n_bus_wr, 0);
    chk("wreq clr cycle1", int'(rec[1].clr), 1);
    chk("wreq clear no read", int'(rec[1].men), 0);
    chk("wreq done cycle", first_done, 137);

    // abort at cycle 50
    run_pass(0, 0, 50, -1, 1'b0);
    stats(50);
    chk("abort busy low", first_idle, 51);
    chk("abort wb after", n_wb_after, 0);
    chk("abort done count", n_done, 0);
    chk("abort wb total", wb_cyc.size(), 1);

    // asynchronous reset in the middle of RUN
    run_pass(0, 0, -1, 40, 1'b0);
    stats(40);
    chk("rst busy immediate", int'(rec[40].bsy), 0);
    chk("rst acc_en after", n_en_after, 0);
    chk("rst done count", n_done, 0);

    // a fresh start reproduces nominal timing
    run_pass(0, 0, -1, -1, 1'b0);
    check_nominal("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wmem_layer_scheduler.md
Name: wmem_layer_scheduler

Overview:
- Sequencing controller for the bit-serial multi-layer engine.
- Owns the single weight-memory port and shares it between host weight writes (idle only) and compute reads (busy).
- Walks the layer → neuron-group (P lanes) → input → bit-plane loops and drives accumulator clear, enable and writeback strobes for the P-lane datapath.
- Sits between host/AXI control and the weight memory plus accumulator lanes.

Parameters:
- PRECISION, 16: activation bits serialised per input, LSB first.
- N_IN, 512: layer-0 fan-in.
- N_HIDDEN, 256: neurons per layer; fan-in of layers ≥1. Must be a multiple of P.
- N_LAYERS, 7: number of layers.
- P, 4: parallel neuron lanes per group.
- DATA_W, 16: weight width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; begins a pass when in IDLE.
- abort  in  1  return to IDLE from any state.
- stall  in  1  freezes RUN counters (activation not ready).
- busy  out  1  high in CLEAR/RUN/WB/DONE.
- done  out  1  one-cycle pulse at pass end.
- w_req  in  1  host weight write request.
- w_ready  out  1  write accepted this cycle.
- w_addr_l  in  $clog2(N_LAYERS)  host layer address.
- w_addr_h  in  $clog2(N_HIDDEN)  host neuron address.
- w_addr_i  in  $clog2(N_IN)  host input address.
- w_data  in  DATA_W  host weight.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write (1) or read (0).
- mem_l  out  $clog2(N_LAYERS)  layer address.
- mem_h  out  $clog2(N_HIDDEN)  neuron address; group base g*P on reads.
- mem_i  out  $clog2(N_IN)  input index.
- mem_wdata  out  DATA_W  write data.
- bit_idx  out  $clog2(PRECISION)  current bit plane.
- bit_msb  out  1  bit_idx==PRECISION-1; lanes subtract (two's complement).
- acc_clr  out  1  clear P accumulators.
- acc_en  out  1  accumulate with current weight/bit.
- acc_wb  out  1  writeback/ReLU of the P results.
- wb_layer  out  $clog2(N_LAYERS)  layer of the current writeback.
- wb_group  out  $clog2(N_HIDDEN/P)  group of the current writeback.

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0.
- States: IDLE, CLEAR, RUN, WB, DONE.
- IDLE:
  - w_ready=w_req, combinational.
  - While w_req: mem_en=mem_we=1 and mem_* = w_* passthrough.
  - start → CLEAR with l=g=i=b=0.
  - start and w_req in the same cycle: both honoured. The write completes this cycle; CLEAR issues no read.
- Busy: w_ready=0, mem_we=0, and host writes are stalled.
- CLEAR: 1 cycle, acc_clr=1 → RUN.
- RUN:
  - mem_en=acc_en=!stall.
  - mem_l=l, mem_h=g*P, mem_i=i, bit_idx=b.
  - Loop: b increments first; at PRECISION-1, b wraps and i increments.
  - fan_in = N_IN when l==0, else N_HIDDEN.
  - At i==fan_in-1 and b==PRECISION-1 (unstalled) → WB.
  - stall holds all counters and outputs acc_en=mem_en=0.
- WB: 1 cycle, acc_wb=1, wb_layer=l, wb_group=g.
  - Next: g+1 → CLEAR.
  - Last group: l+1 with g=0 → CLEAR.
  - Last layer → DONE.
- DONE: done=1 for 1 cycle → IDLE.
- Cycles per pass, unstalled: sum over layers of (N_HIDDEN/P)·(fan_in·PRECISION + 2), plus 1 for DONE.
- abort: any state → IDLE next edge. No acc_wb or done pulse follows; counters clear.
- Timing: mem read data returns next cycle (memory latency 1). acc_en is aligned with the address cycle; the datapath delays it internally by the same latency.
- Counters never exceed their bounds. No wrap other than the defined loop carries.

Test Plan:
All scenarios use N_IN=8, N_HIDDEN=8, N_LAYERS=2, P=4, PRECISION=4 unless stated.

1. Reset → all outputs 0, state IDLE. w_req=1 in IDLE with addr (1,5,3), data 0x1234 → w_ready=1, mem_en=mem_we=1, mem_l=1, mem_h=5, mem_i=3, mem_wdata=0x1234 in the same cycle.
2. start pulse at edge T0, no stall → acc_clr cycle 1, acc_en cycles 2–33, acc_wb cycle 34 (group 0) and cycle 68 (group 1, layer 0), layer-1 writebacks at cycles 102 and 136, done cycle 137, busy low at 138. Exactly 128 acc_en cycles total. bit_msb is high every 4th acc_en cycle.
3. Address sweep → first read (0,0,0) with bit 0; 4th read (0,0,0) with bit 3; 5th read (0,0,1). Layer-1 group-1 reads carry mem_h=4.
4. stall high for 5 cycles mid-RUN → counters and outputs frozen, acc_en=0 during stall, done delayed by exactly 5 cycles (cycle 142).
5. w_req held during busy → w_ready=0 and mem_we=0 throughout. start and w_req coincident in IDLE → write executes and CLEAR follows.
6. abort at cycle 50, and async rst asserted mid-RUN → IDLE next edge (rst: immediately), no done or acc_wb. A fresh start then reproduces the scenario-2 timing.
